// File: rtl/scan_cfg_pkg.sv
// Shared definitions for the scan chain loader: FSM encoding and counter sizing.
package scan_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Bits needed to count from 0 up to and including n.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/scan_chain_loader_if.sv
// Word stream, control and chain-side signals of the scan chain loader.
// master: bitstream source / chain side, slave: the loader itself.
interface scan_chain_loader_if #(
   parameter int WORD_WIDTH = 8
);
   logic                  start;
   logic                  in_valid;
   logic                  in_ready;
   logic [WORD_WIDTH-1:0] in_data;
   logic                  busy;
   logic                  done;
   logic                  scan_in;
   logic                  scan_en;
   logic                  scan_wen;
   logic                  scan_out;
   logic                  rb_valid;
   logic [WORD_WIDTH-1:0] rb_data;

   modport master (
      output start, in_valid, in_data, scan_out,
      input  in_ready, busy, done, scan_in, scan_en, scan_wen, rb_valid, rb_data
   );

   modport slave (
      input  start, in_valid, in_data, scan_out,
      output in_ready, busy, done, scan_in, scan_en, scan_wen, rb_valid, rb_data
   );
endinterface

// File: rtl/scan_chain_loader_word_serializer.sv
// Loadable right-shifting word register with a remaining-bit counter.
// New bits enter at the MSB end, so the same block serializes (read bit 0)
// and deserializes (first bit in ends up nearest bit 0).
module scan_word_serializer
   import scan_cfg_pkg::*;
#(
   parameter int WORD_WIDTH = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                load,
   input  logic [WORD_WIDTH-1:0]               load_data,
   input  logic [cnt_width(WORD_WIDTH)-1:0]    load_count,
   input  logic                                shift,
   input  logic                                shift_in,
   output logic [WORD_WIDTH-1:0]               data,
   output logic                                last
);
   localparam int LW = cnt_width(WORD_WIDTH);

   logic [LW-1:0] remaining;

   // Load a fresh word, or shift one bit and count it off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data      <= '0;
         remaining <= '0;
      end else if (load) begin
         data      <= load_data;
         remaining <= load_count;
      end else if (shift) begin
         data <= (data >> 1) | (WORD_WIDTH'(shift_in) << (WORD_WIDTH - 1));
         if (remaining != '0) begin
            remaining <= remaining - LW'(1);
         end
      end
   end

   assign last = (remaining == LW'(1));

endmodule

// File: rtl/scan_chain_loader.sv
// Scan chain loader: takes configuration words over a valid/ready stream and
// shifts them LSB-first into the fabric scan chain, CHAIN_LEN bits per load.
// Optional readback of the bits leaving the chain tail: SCAN_LOADER_READBACK_EN.
//
// state | meaning
// IDLE  | waiting for start, chain untouched
// LOAD  | in_ready high, waiting for the next word
// SHIFT | scan_en/scan_wen high, one word bit per cycle onto scan_in
// DONE  | one-cycle done pulse, back to IDLE
module scan_chain_loader
   import scan_cfg_pkg::*;
#(
   parameter int CHAIN_LEN  = 64,
   parameter int WORD_WIDTH = 8
) (
   input logic                clk,
   input logic                rst,
   scan_chain_loader_if.slave bus
);
   localparam int CW = cnt_width(CHAIN_LEN);
   localparam int LW = cnt_width(WORD_WIDTH);

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_next;
   logic [31:0]           chain_left;
   logic [LW-1:0]         load_count;
   logic                  in_ready_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  scan_en_q;
   logic                  ld_load;
   logic                  ld_shift;
   logic                  ld_last;
   logic [WORD_WIDTH-1:0] ld_data;

   assign cnt_next   = cnt + CW'(1);
   assign chain_left = 32'(CHAIN_LEN) - 32'(cnt);
   // The last word of a load may carry fewer useful bits than WORD_WIDTH.
   assign load_count = (chain_left < 32'(WORD_WIDTH)) ? LW'(chain_left) : LW'(WORD_WIDTH);
   assign ld_load    = (state == LOAD) && bus.in_valid;
   assign ld_shift   = (state == SHIFT);

   scan_word_serializer #(.WORD_WIDTH(WORD_WIDTH)) u_load (
      .clk       (clk),
      .rst       (rst),
      .load      (ld_load),
      .load_data (bus.in_data),
      .load_count(load_count),
      .shift     (ld_shift),
      .shift_in  (1'b0),
      .data      (ld_data),
      .last      (ld_last)
   );

   // Sequencing FSM with registered handshake and scan-enable outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         scan_en_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state      <= LOAD;
                  cnt        <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            LOAD: begin
               if (bus.in_valid) begin
                  state      <= SHIFT;
                  in_ready_q <= 1'b0;
                  scan_en_q  <= 1'b1;
               end
            end
            SHIFT: begin
               cnt <= cnt_next;
               if (ld_last) begin
                  scan_en_q <= 1'b0;
                  if (cnt_next == CW'(CHAIN_LEN)) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state      <= LOAD;
                     in_ready_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.scan_en  = scan_en_q;
   assign bus.scan_wen = scan_en_q;
   // Gated so leftover upper bits of a partial word never appear on the chain head.
   assign bus.scan_in  = scan_en_q & ld_data[0];

`ifdef SCAN_LOADER_READBACK_EN
   logic [WORD_WIDTH-1:0] rb_sr;
   logic [WORD_WIDTH-1:0] rb_next;
   logic [WORD_WIDTH-1:0] rb_q;
   logic [LW-1:0]         word_len;
   logic                  rb_last;
   logic                  rb_valid_q;
   logic                  unused_ld;

   scan_word_serializer #(.WORD_WIDTH(WORD_WIDTH)) u_rb (
      .clk       (clk),
      .rst       (rst),
      .load      (ld_load),
      .load_data ('0),
      .load_count(load_count),
      .shift     (ld_shift),
      .shift_in  (bus.scan_out),
      .data      (rb_sr),
      .last      (rb_last)
   );

   // Value the readback register holds once the current tail bit is taken in.
   assign rb_next = (rb_sr >> 1) | (WORD_WIDTH'(bus.scan_out) << (WORD_WIDTH - 1));

   // Publish each collected word, right-aligned, the cycle after its last bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rb_q       <= '0;
         rb_valid_q <= 1'b0;
         word_len   <= '0;
      end else begin
         rb_valid_q <= ld_shift & rb_last;
         if (ld_load) begin
            word_len <= load_count;
         end
         if (ld_shift & rb_last) begin
            rb_q <= rb_next >> (LW'(WORD_WIDTH) - word_len);
         end
      end
   end

   assign bus.rb_valid = rb_valid_q;
   assign bus.rb_data  = rb_q;
   // Only bit 0 of the load register ever drives the chain.
   assign unused_ld    = ^ld_data;
`else
   logic unused_ld;

   assign bus.rb_valid = 1'b0;
   assign bus.rb_data  = '0;
   // Without readback the chain tail and the upper load bits go nowhere.
   assign unused_ld    = ^{ld_data, bus.scan_out};
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader: 20-bit chain model, 8-bit words, scoreboard of
// expected scan_in bits and readback words checked by a negedge monitor.
module tb_scan_chain_loader;
   localparam int CL = 20;
   localparam int WW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   scan_chain_loader_if #(.WORD_WIDTH(WW)) bus ();

   scan_chain_loader #(.CHAIN_LEN(CL), .WORD_WIDTH(WW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [CL-1:0] chain;
   logic          chain_clr = 1'b0;
   logic          chain_set = 1'b0;

   logic          exp_bits[$];
   logic [WW-1:0] exp_rb[$];

   int shift_cnt, load_cnt, done_cnt, rb_cnt, load_cyc, done_cyc;

   // Cycle counter for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   // Chain model: position 0 is the head, CL-1 the tail.
   always @(posedge clk) begin
      if (chain_clr)         chain <= '0;
      else if (chain_set)    chain <= '1;
      else if (bus.scan_en)  chain <= {chain[CL-2:0], bus.scan_in};
   end
   assign bus.scan_out = chain[CL-1];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s: output with no expected entry", name);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a scan bit or readback word.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.scan_en) begin
            shift_cnt++;
            check("scan_wen", bus.scan_wen, 1);
            if (exp_bits.size() == 0) unexpected("scan_bit");
            else check("scan_in", bus.scan_in, exp_bits.pop_front());
         end
         if (bus.in_ready) begin
            load_cnt++;
            if (load_cyc < 0) load_cyc = cyc;
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (bus.rb_valid) begin
            rb_cnt++;
            if (exp_rb.size() == 0) unexpected("rb_word");
            else check("rb_data", bus.rb_data, exp_rb.pop_front());
         end
      end
   end

   task automatic clear_stats();
      shift_cnt = 0;
      load_cnt  = 0;
      done_cnt  = 0;
      rb_cnt    = 0;
      load_cyc  = -1;
      done_cyc  = -1;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic pulse_chain(input bit set);
      if (set) chain_set = 1'b1;
      else     chain_clr = 1'b1;
      @(negedge clk);
      chain_set = 1'b0;
      chain_clr = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_in_ready"}, bus.in_ready, 0);
      check({tag, "_busy"},     bus.busy,     0);
      check({tag, "_done"},     bus.done,     0);
      check({tag, "_scan_in"},  bus.scan_in,  0);
      check({tag, "_scan_en"},  bus.scan_en,  0);
      check({tag, "_scan_wen"}, bus.scan_wen, 0);
      check({tag, "_rb_valid"}, bus.rb_valid, 0);
      check({tag, "_rb_data"},  bus.rb_data,  0);
   endtask

   task automatic run_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                           input logic [WW-1:0] w2, input bit stall, input bit poke,
                           input logic [CL-1:0] exp_chain, input int exp_lat,
                           input int exp_loads);
      logic [WW-1:0] w[3];
      int  pushed;
      int  n;
      bit  ok;
      bit  stall_ok;
      w[0] = w0;
      w[1] = w1;
      w[2] = w2;
      pushed = 0;
      clear_stats();
      for (int i = 0; i < 3; i++) begin
         n = (CL - pushed < WW) ? CL - pushed : WW;
         for (int b = 0; b < n; b++) exp_bits.push_back(w[i][b]);
         pushed += n;
      end
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_data = w[i];
         if (stall && i == 1) begin
            bus.in_valid = 1'b0;
            wait_ready(ok);
            check("stall_ready_seen", ok, 1);
            stall_ok = 1'b1;
            for (int k = 0; k < 5; k++) begin
               if (bus.scan_en !== 1'b0 || bus.scan_wen !== 1'b0) stall_ok = 1'b0;
               @(negedge clk);
            end
            check("stall_scan_en_low", stall_ok, 1);
         end
         bus.in_valid = 1'b1;
         wait_ready(ok);
         check("in_ready_seen", ok, 1);
         @(negedge clk);
         if (poke && i == 0) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
         end
      end
      bus.in_valid = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (bus.done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("done_seen", ok, 1);
      @(negedge clk);
      check("busy_after_done", bus.busy, 0);
      check("done_one_cycle", bus.done, 0);
      @(negedge clk);
      check("shift_cycles", shift_cnt, CL);
      check("load_cycles", load_cnt, exp_loads);
      check("done_pulses", done_cnt, 1);
      check("done_latency", done_cyc - load_cyc, exp_lat);
      check("chain_contents", chain, exp_chain);
      check("bits_left", exp_bits.size(), 0);
   endtask

   initial begin
      bit ok;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      chain_clr    = 1'b1;
      clear_stats();
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst       = 1'b0;
      chain_clr = 1'b0;
      @(negedge clk);
      check("idle_busy", bus.busy, 0);

      // Serial order and final placement, in_valid held high.
      run_load(8'hA5, 8'h3C, 8'h0F, 1'b0, 1'b0, 20'hA53CF, 23, 3);
      check("tail_is_a5_bit0", chain[CL-1], 1);
      check("head_is_0f_bit3", chain[0], 1);
`ifndef SCAN_LOADER_READBACK_EN
      check("rb_pulses_absent", rb_cnt, 0);
      check("rb_data_tied", bus.rb_data, 0);
`endif

      // Stall of 5 cycles before the second word.
      pulse_chain(1'b0);
      run_load(8'hA5, 8'h3C, 8'h0F, 1'b1, 1'b0, 20'hA53CF, 28, 8);

      // start pulsed during SHIFT is ignored.
      run_load(8'h5A, 8'hC3, 8'hF0, 1'b0, 1'b1, 20'h5AC30, 23, 3);

`ifdef SCAN_LOADER_READBACK_EN
      // Readback returns the previous chain contents word by word.
      pulse_chain(1'b1);
      exp_rb.push_back(8'hFF);
      exp_rb.push_back(8'hFF);
      exp_rb.push_back(8'h0F);
      run_load(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 20'h00000, 23, 3);
      check("rb_pulses", rb_cnt, 3);
      check("rb_left", exp_rb.size(), 0);
`endif

      // Reset in the middle of SHIFT.
      clear_stats();
      for (int b = 0; b < WW; b++) exp_bits.push_back(1'b1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_data  = 8'hFF;
      bus.in_valid = 1'b1;
      wait_ready(ok);
      check("mid_ready_seen", ok, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("mid_in_shift", bus.scan_en, 1);
      rst = 1'b1;
      #1;
      check_outputs_zero("mid_reset");
      exp_bits.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("post_reset_busy", bus.busy, 0);
      check("post_reset_ready", bus.in_ready, 0);

      // Full reload after the interrupted one.
      run_load(8'hA5, 8'h3C, 8'h0F, 1'b0, 1'b0, 20'hA53CF, 23, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

endmodule

// File: doc/scan_chain_loader.md
# scan_chain_loader

Configuration loader that drives the FPGA fabric's scan chain of scannable 1-bit registers. It accepts configuration words over a valid/ready stream, serializes them LSB-first onto `scan_in`, and asserts `scan_en` and `scan_wen` for exactly `CHAIN_LEN` shift cycles. It sits between the bitstream source (host interface or ROM reader) and the head of the configuration chain. Optionally, it captures the bits leaving the chain tail for readback.

## Interface
- `CHAIN_LEN`, default 64: total scannable bits in the chain; must be ≥ 1.
- `WORD_WIDTH`, default 8: configuration word width; must be ≥ 1.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: one-cycle request to begin a load; honoured only in IDLE.
- `in_valid` input 1: configuration word valid.
- `in_ready` output 1: loader can accept a word.
- `in_data` input WORD_WIDTH: configuration word; bit 0 is shifted first.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a load completes.
- `scan_in` output 1: serial data to the chain head.
- `scan_en` output 1: chain scan-mode select.
- `scan_wen` output 1: chain write enable.
- `scan_out` input 1: serial data from the chain tail.
- `rb_valid` output 1: readback word valid, one-cycle pulse.
- `rb_data` output WORD_WIDTH: readback word.

## Operation
- FSM states are IDLE, LOAD, SHIFT and DONE. All transitions occur on the rising edge of `clk`.
- **IDLE:** on `start`=1, go to LOAD and clear the bit counter.
- **LOAD:** `in_ready`=1. When `in_valid`&`in_ready`, capture `in_data` into the shift register, set the word-bit count to min(`WORD_WIDTH`, `CHAIN_LEN` − shifted), and go to SHIFT.
- **SHIFT:** each cycle drives `scan_en`=`scan_wen`=1 and `scan_in`=shreg[0]. On the edge, shreg shifts right, the bit counter increments and the word-bit count decrements.
  - On the last bit of a word: go to DONE if the total shifted equals `CHAIN_LEN`, otherwise go to LOAD.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- Bit placement: the first bit shifted ends at the chain position farthest from `scan_in`. The last bit shifted sits at the chain head.
- Partial final word: when `CHAIN_LEN` is not a multiple of `WORD_WIDTH`, the upper bits of the last word are discarded.
- `start` while busy is ignored. `in_valid` outside LOAD is not accepted.
- `scan_en` and `scan_wen` are 0 in IDLE, LOAD and DONE, so the chain holds its value.
- Counter width is $clog2(`CHAIN_LEN`+1). The counter never exceeds `CHAIN_LEN`.

## Timing
- Reset values: state IDLE; `in_ready`, `busy`, `done`, `scan_in`, `scan_en`, `scan_wen`, `rb_valid` = 0; `rb_data` = 0; counters and shift registers = 0.
- `start` at edge N puts the FSM in LOAD in cycle N+1.
- A word handshaken in cycle k has bit 0 on `scan_in` in cycle k+1.
- Each word costs one LOAD cycle plus its shift cycles. With `in_valid` held high, a full load takes ceil(`CHAIN_LEN`/`WORD_WIDTH`) + `CHAIN_LEN` cycles from entering LOAD to entering DONE.
- Stalls: if `in_valid` is low, LOAD waits indefinitely and the chain is untouched.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Chain contents are partially shifted; a full reload is required afterwards.
- `busy` falls in the cycle after DONE.

## Configuration
- `SCAN_LOADER_READBACK_EN` defined:
  - In each SHIFT cycle, `scan_out` is sampled on the edge into a readback shift register, filling from the MSB end so that the first bit out lands in bit 0.
  - When a word's shift bits finish, `rb_valid` pulses for one cycle in the following cycle. `rb_data` holds the collected bits, right-aligned for a partial last word, with upper bits 0.
  - This returns the previous chain contents, in the same word order as loading.
- Macro undefined: the readback logic is absent. `rb_valid` and `rb_data` remain as ports and are tied to 0.

## Structure
- Shared package `scan_cfg_pkg`: FSM state encoding constants (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3) and the counter-width function.
- One sub-module, `scan_word_serializer`: a loadable `WORD_WIDTH` shift register with a remaining-bit counter. It is instantiated once for the load path, and once more for readback when `SCAN_LOADER_READBACK_EN` is defined.

## Test plan
Bench uses `CHAIN_LEN`=20, `WORD_WIDTH`=8, and a chain model of 20 scannable registers.
- Reset values: assert `rst` mid-SHIFT → all outputs 0 in the same cycle; FSM in IDLE.
- Serial order: `start`, then words 0xA5, 0x3C, 0x0F with `in_valid` held high → `scan_in` first 8 bits 1,0,1,0,0,1,0,1; 20 shift cycles total; 3 LOAD cycles; `done` pulses once, 23 cycles after entering LOAD.
- Final placement: after the load above → chain position 19 = 1 (0xA5 bit 0), chain head = 0x0F bit 3 = 1; bits 4–7 of 0x0F are never shifted.
- Stall: `in_valid` dropped for 5 cycles after the first word → `scan_en` stays 0 for those cycles; final chain contents identical to the no-stall run.
- `start` while busy: pulse `start` during SHIFT → no restart; cycle count unchanged.
- Readback (macro defined): preload chain to 0xFFFFF, then load 0x00,0x00,0x00 → `rb_data` = 0xFF, 0xFF, 0x0F on three `rb_valid` pulses; chain ends at 0.
